// File: rtl/seg7_pkg.sv
// Shared types and active-low glyph constants for the 7-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seg7_pkg;
    typedef logic [3:0] digit_code_t;
    typedef logic [6:0] seg_t;

    localparam digit_code_t CODE_BLANK = 4'hF;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low segment decoder.
// Codes A..E render a dash; CODE_BLANK turns every segment off.
module seg7_decode
    import seg7_pkg::*;
(
    input  digit_code_t code,
    output seg_t        seg
);
    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_BLANK: seg = SEG_BLANK;
            default:    seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 5-digit driver with per-frame snapshot and dead time.
// Optional macro SCAN_DIMMING_EN adds a 3-bit bright input for PWM dimming of the lit window.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 8,
    parameter int N_DIG     = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       in6,
    input  logic [3:0]       in5,
    input  logic [3:0]       in4,
    input  logic [3:0]       in3,
    input  logic [3:0]       in2,
    input  logic [N_DIG-1:0] dp_mask,
`ifdef SCAN_DIMMING_EN
    input  logic [2:0]       bright,
`endif
    output seg_t             seg,
    output logic             dp,
    output logic [N_DIG-1:0] an,
    output logic             frame_tick
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]                presc;
    logic [2:0]                   idx;
    logic [N_DIG-1:0][3:0]        snap;
    logic [N_DIG-1:0]             dp_snap;
    logic                         wrap, frame_end, lit, dim_on;
    logic [2:0]                   pos_sel;
    logic [N_DIG-1:0]             an_lit;
    digit_code_t                  cur_code;
    seg_t                         dec_seg;

    assign wrap      = (presc == PW'(SCAN_DIV - 1));
    assign frame_end = wrap && (idx == 3'(N_DIG - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= wrap ? '0 : presc + PW'(1);
            if (wrap)
                idx <= (idx == 3'(N_DIG - 1)) ? 3'd0 : idx + 3'd1;
        end
    end

    // Snapshot index 0 holds in6 so idx addresses it directly in scan order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            snap    <= {N_DIG{CODE_BLANK}};
            dp_snap <= '0;
        end else if (frame_end) begin
            snap    <= {in2, in3, in4, in5, in6};
            dp_snap <= dp_mask;
        end
    end

`ifdef SCAN_DIMMING_EN
    logic [2:0]    bright_q;
    logic [PW-1:0] lit_pos;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            bright_q <= 3'd7;
        else if (frame_end) bright_q <= bright;
    end

    assign lit_pos = presc - PW'(BLANK_CYC);
    assign dim_on  = (lit_pos[2:0] <= bright_q);
`else
    assign dim_on = 1'b1;
`endif

    assign cur_code = snap[idx];
    assign pos_sel  = 3'(N_DIG - 1) - idx;
    assign an_lit   = ~(N_DIG'(1) << pos_sel);
    assign lit      = (presc >= PW'(BLANK_CYC)) && dim_on;

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // Segment data moves only at slot start, which always falls inside the dark window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= dec_seg;
            dp         <= ~dp_snap[pos_sel];
            an         <= lit ? an_lit : '1;
            frame_tick <= frame_end;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at SCAN_DIV=16, BLANK_CYC=2 (80-cycle frames).
module tb_seg7_scan_driver;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] in6, in5, in4, in3, in2;
    logic [4:0] dp_mask;
    logic [6:0] seg;
    logic       dp;
    logic [4:0] an;
    logic       frame_tick;
`ifdef SCAN_DIMMING_EN
    logic [2:0] bright = 3'd7;
`endif

    always #5 CLK = ~CLK;

    seg7_scan_driver #(.SCAN_DIV(16), .BLANK_CYC(2), .N_DIG(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in6        (in6),
        .in5        (in5),
        .in4        (in4),
        .in3        (in3),
        .in2        (in2),
        .dp_mask    (dp_mask),
`ifdef SCAN_DIMMING_EN
        .bright     (bright),
`endif
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [4:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t       sb[$];
    int         passed = 0;
    int         total  = 0;
    int         cyc    = 0;
    logic [3:0] cur [5];
    logic [4:0] cur_dp;
    logic [6:0] lit_seg [5];
    logic       lit_dp  [5];
    int         lit_cnt [5];
    int         dark_cnt[5];
    int         seg_glitch;
    int         tick_at;
    logic [6:0] prev_seg;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            4'hF: return 7'h7F;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic blank_model();
        for (int s = 0; s < 5; s++) cur[s] = 4'hF;
        cur_dp = 5'b0;
    endtask

    task automatic clear_stats();
        for (int s = 0; s < 5; s++) begin
            lit_seg[s]  = 7'hxx;
            lit_dp[s]   = 1'bx;
            lit_cnt[s]  = 0;
            dark_cnt[s] = 0;
        end
        seg_glitch = 0;
        tick_at    = -1;
        prev_seg   = seg;
    endtask

    // Sample n (after the n-th edge since release) shows slot state of cycle n-1.
    task automatic run_cycles(input int k);
        for (int j = 0; j < k; j++) begin
            int         n, p, i;
            logic [4:0] onehot;
            exp_t       e, o;
            n      = cyc + 1;
            p      = (n - 1) % 16;
            i      = ((n - 1) / 16) % 5;
            onehot = 5'b00001 << (4 - i);
            e.an   = (p < 2) ? 5'h1F : ~onehot;
            e.seg  = glyph(cur[i]);
            e.dp   = ~cur_dp[4 - i];
            e.ft   = (n % 80 == 0);
            sb.push_back(e);
            if (n % 80 == 0) begin
                cur[0] = in6; cur[1] = in5; cur[2] = in4; cur[3] = in3; cur[4] = in2;
                cur_dp = dp_mask;
            end
            @(posedge CLK); #1;
            cyc = n;
            e = sb.pop_front();
            o = {an, seg, dp, frame_tick};
            total++;
            if (o !== e)
                $display("FAIL scan n=%0d: an/seg/dp/tick got %b/%h/%b/%b want %b/%h/%b/%b",
                         n, o.an, o.seg, o.dp, o.ft, e.an, e.seg, e.dp, e.ft);
            else
                passed++;
            if (frame_tick === 1'b1 && tick_at < 0) tick_at = n;
            if (seg !== prev_seg && an !== 5'h1F) seg_glitch++;
            prev_seg = seg;
            if (an === 5'h1F) dark_cnt[i]++;
            else begin
                lit_cnt[i]++;
                lit_seg[i] = seg;
                lit_dp[i]  = dp;
            end
        end
    endtask

    task automatic run_frame();
        clear_stats();
        run_cycles(80);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        {in6, in5, in4, in3, in2} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        dp_mask = 5'b0;
        blank_model();
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if ({an, seg, dp, frame_tick} !== {5'h1F, 7'h7F, 1'b1, 1'b0})
            $display("FAIL reset_state: an/seg/dp/tick got %b/%h/%b/%b want 11111/7f/1/0",
                     an, seg, dp, frame_tick);
        else passed++;
        RST = 1'b0;
        cyc = 0;
        run_frame();
        total++;
        if (tick_at !== 80) $display("FAIL first_tick: got cycle %0d want 80", tick_at);
        else passed++;
        for (int s = 0; s < 5; s++) begin
            total++;
            if (lit_seg[s] !== 7'h7F || lit_dp[s] !== 1'b1)
                $display("FAIL dark_frame slot%0d: seg/dp got %h/%b want 7f/1", s, lit_seg[s], lit_dp[s]);
            else passed++;
        end
    endtask

    task automatic test_static_digits();
        logic [6:0] want [5];
        want = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
        run_frame();
        for (int s = 0; s < 5; s++) begin
            total++;
            if (lit_cnt[s] !== 14 || lit_seg[s] !== want[s])
                $display("FAIL static slot%0d: lit/seg got %0d/%h want 14/%h", s, lit_cnt[s], lit_seg[s], want[s]);
            else passed++;
        end
    endtask

    task automatic test_blank_dash_dp();
        in4 = 4'hF; in3 = 4'hB; dp_mask = 5'b00100;
        run_frame();
        total++;
        if (lit_seg[2] !== 7'h30) $display("FAIL pre_snapshot slot2: seg got %h want 30", lit_seg[2]);
        else passed++;
        run_frame();
        total++;
        if (lit_seg[2] !== 7'h7F || lit_cnt[2] !== 14 || lit_dp[2] !== 1'b0)
            $display("FAIL blank_dp slot2: seg/lit/dp got %h/%0d/%b want 7f/14/0", lit_seg[2], lit_cnt[2], lit_dp[2]);
        else passed++;
        total++;
        if (lit_seg[3] !== 7'h3F || lit_dp[3] !== 1'b1 || lit_dp[1] !== 1'b1)
            $display("FAIL dash slot3: seg/dp3/dp1 got %h/%b/%b want 3f/1/1", lit_seg[3], lit_dp[3], lit_dp[1]);
        else passed++;
    endtask

    task automatic test_midframe_change();
        clear_stats();
        run_cycles(30);
        in5 = 4'd7;
        run_cycles(50);
        total++;
        if (lit_seg[1] !== 7'h24) $display("FAIL midframe_hold: seg got %h want 24", lit_seg[1]);
        else passed++;
        run_frame();
        total++;
        if (lit_seg[1] !== 7'h78) $display("FAIL midframe_update: seg got %h want 78", lit_seg[1]);
        else passed++;
    endtask

    task automatic test_ghosting();
        run_frame();
        for (int s = 0; s < 5; s++) begin
            total++;
            if (dark_cnt[s] !== 2) $display("FAIL ghost_window slot%0d: dark got %0d want 2", s, dark_cnt[s]);
            else passed++;
        end
        total++;
        if (seg_glitch !== 0) $display("FAIL ghost_seg: lit seg changes got %0d want 0", seg_glitch);
        else passed++;
    endtask

    task automatic test_reset_midslot();
        run_cycles(37);
        #2 RST = 1'b1;
        #1;
        total++;
        if ({an, seg, dp, frame_tick} !== {5'h1F, 7'h7F, 1'b1, 1'b0})
            $display("FAIL async_reset: an/seg/dp/tick got %b/%h/%b/%b want 11111/7f/1/0",
                     an, seg, dp, frame_tick);
        else passed++;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        cyc = 0;
        blank_model();
        run_frame();
        total++;
        if (tick_at !== 80 || lit_seg[0] !== 7'h7F || dark_cnt[0] !== 2)
            $display("FAIL restart: tick/seg0/dark0 got %0d/%h/%0d want 80/7f/2", tick_at, lit_seg[0], dark_cnt[0]);
        else passed++;
        run_frame();
        total++;
        if (lit_seg[1] !== 7'h78 || lit_seg[0] !== 7'h79)
            $display("FAIL restart_content: seg1/seg0 got %h/%h want 78/79", lit_seg[1], lit_seg[0]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_static_digits();
        test_blank_dash_dp();
        test_midframe_change();
        test_ghosting();
        test_reset_midslot();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
